// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types, defaults and address range helper for the dmem port arbiter
package dmem_arb_pkg;
  typedef enum logic {ARB, LOCKED} arb_state_t;
  localparam int MAX_BURST_DEF = 4;
  localparam int DEPTH_WORDS_DEF = 1024;
  function automatic logic in_range(input logic [31:0] addr, input int depth);
    return {2'b00, addr[31:2]} < 32'(depth);
  endfunction
endpackage

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares dmem port 0 between the CPU and a valid/ready peripheral,
// with CPU priority, a starvation bound and a peripheral lock for atomic sequences
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        cpu_stall,
  input  logic        per_valid,
  output logic        per_ready,
  input  logic        per_we,
  input  logic        per_lock,
  input  logic [31:0] per_addr,
  input  logic [31:0] per_wd,
  output logic [31:0] per_rdata,
  output logic        per_rvalid,
  output logic        per_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  arb_state_t state_q, state_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [31:0] per_rdata_q, per_rdata_d;
  logic per_rvalid_q, per_rvalid_d, per_err_q, per_err_d;
  logic cpu_gnt, per_gnt, cpu_ir, per_ir;
  // Grants are gated by rst_n so nothing reaches memory while reset is held.
  always_comb begin
    cpu_ir = in_range(cpu_addr, DEPTH_WORDS);
    per_ir = in_range(per_addr, DEPTH_WORDS);
    per_gnt = rst_n & per_valid & ((state_q == LOCKED) | ~cpu_req | (burst_cnt_q == BURST_MAX));
    cpu_gnt = rst_n & cpu_req & ~per_gnt & (state_q == ARB);
    per_ready = per_gnt;
    cpu_stall = cpu_req & ~cpu_gnt;
    cpu_rd = (cpu_gnt & cpu_ir) ? mem_rd : '0;
    mem_addr = per_gnt ? per_addr : cpu_addr;
    mem_wd = per_gnt ? per_wd : cpu_wd;
    mem_we = per_gnt ? (per_we & per_ir) : (cpu_gnt & cpu_we & cpu_ir);
    burst_cnt_d = (cpu_gnt & per_valid) ? ((burst_cnt_q == BURST_MAX) ? burst_cnt_q : burst_cnt_q + 1'b1)
                : (per_gnt | ~per_valid) ? '0 : burst_cnt_q;
    state_d = per_gnt ? (per_lock ? LOCKED : ARB) : state_q;
    per_rvalid_d = per_gnt & ~per_we & per_ir;
    per_err_d = per_gnt & ~per_ir;
    per_rdata_d = per_rvalid_d ? mem_rd : per_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB;
      burst_cnt_q <= '0;
      per_rdata_q <= '0;
      per_rvalid_q <= 1'b0;
      per_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_cnt_q <= burst_cnt_d;
      per_rdata_q <= per_rdata_d;
      per_rvalid_q <= per_rvalid_d;
      per_err_q <= per_err_d;
    end
  end
  assign per_rdata = per_rdata_q;
  assign per_rvalid = per_rvalid_q;
  assign per_err = per_err_q;
endmodule
